// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared CPU definitions used by the instruction-fetch block:
//   - INST_W / BYTE_W : instruction and memory byte widths
//   - fetch_state_t   : fetch FSM states (IDLE, READ)
//   - byte_idx_t      : index of a byte within an instruction word
//   - insert_byte()   : places byte k of a big-endian word (byte 0 -> [31:24])
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam int INST_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } fetch_state_t;

    typedef logic [1:0] byte_idx_t;

    // Big-endian byte lane insert: byte 0 is the most significant byte.
    function automatic logic [INST_W-1:0] insert_byte(
        input logic [INST_W-1:0] word,
        input byte_idx_t         idx,
        input logic [BYTE_W-1:0] b
    );
        logic [INST_W-1:0] r;
        r = word;
        case (idx)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Byte-wide, valid-qualified instruction-memory read port.
//   mem_rd    : read request (master -> memory)
//   mem_addr  : byte address of the current read (master -> memory)
//   mem_data  : read data, meaningful while mem_valid=1 (memory -> master)
//   mem_valid : read-data strobe (memory -> master)
// -----------------------------------------------------------------------------
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic              mem_rd;
    logic [INST_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_data;
    logic              mem_valid;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_data,
        input  mem_valid
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_data,
        output mem_valid
    );

endinterface

// File: rtl/inst_fetch_wait_timer.sv
// -----------------------------------------------------------------------------
// fetch_wait_timer
// Counts stalled read cycles for the byte currently being fetched.
//   clk       : system clock
//   i_srst    : synchronous active-high reset
//   i_clear   : restart the count (takes priority over i_enable)
//   i_enable  : count one stalled cycle
//   o_expired : this is the TIMEOUT-th stalled cycle; if the memory still
//               does not answer now, the byte read is abandoned
// -----------------------------------------------------------------------------
module fetch_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic i_srst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (i_srst || i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Flag one cycle early so mem_rd is high for exactly TIMEOUT cycles.
    assign o_expired = (r_count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Fetches a 32-bit instruction as four sequential byte reads, assembles it
// big-endian and commits it to the instruction register.
//   clk          : system clock
//   i_reset      : synchronous active-high reset
//   i_fetch_req  : start a fetch (only looked at while idle)
//   i_address    : instruction byte address, latched on accept
//   mem_if       : byte-wide instruction memory port (master side)
//   o_ir         : instruction register
//   o_fetch_done : one-cycle pulse, o_ir updated this cycle
//   o_fetch_err  : one-cycle pulse, fetch aborted (misaligned or timeout)
//   o_busy       : fetch in progress
// -----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_fetch_req,
    input  logic [INST_W-1:0]  i_address,
    inst_fetch_if.master       mem_if,
    output logic [INST_W-1:0]  o_ir,
    output logic               o_fetch_done,
    output logic               o_fetch_err,
    output logic               o_busy
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [29:0]       r_base_word;   // base address without its (zero) low bits
    byte_idx_t         r_idx;
    logic [INST_W-1:0] r_shadow;
    logic [INST_W-1:0] r_ir;
    logic              r_done;
    logic              r_err;

    logic w_reading;
    logic w_accept;
    logic w_misalign;
    logic w_capture;
    logic w_last;
    logic w_expired;
    logic w_timeout;

    assign w_reading  = (r_state == READ);
    assign w_accept   = (r_state == IDLE) && i_fetch_req && (i_address[1:0] == 2'b00);
    assign w_misalign = (r_state == IDLE) && i_fetch_req && (i_address[1:0] != 2'b00);
    // mem_valid only counts while a read is actually being requested.
    assign w_capture  = w_reading && mem_if.mem_valid;
    assign w_last     = w_capture && (r_idx == 2'd3);
    assign w_timeout  = w_reading && !mem_if.mem_valid && w_expired;

    fetch_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .i_srst    (i_reset),
        .i_clear   (!w_reading || w_capture),
        .i_enable  (w_reading && !mem_if.mem_valid),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept)             w_state_next = READ;
            READ: if (w_last || w_timeout)  w_state_next = IDLE;
            default:                        w_state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; the address is held until the byte lands.
    always_comb begin
        mem_if.mem_rd   = w_reading;
        mem_if.mem_addr = w_reading ? {r_base_word, r_idx} : '0;
        o_busy          = w_reading;
    end

    // Byte assembly, IR commit and completion pulses
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_base_word <= '0;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_ir        <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= w_last;
            r_err  <= w_misalign || w_timeout;
            if (w_accept) begin
                r_base_word <= i_address[31:2];
                r_idx       <= 2'd0;
                r_shadow    <= '0;
            end
            if (w_capture) begin
                r_shadow <= insert_byte(r_shadow, r_idx, mem_if.mem_data);
                if (!w_last) begin
                    r_idx <= r_idx + 2'd1;
                end
            end
            // IR only moves on a completed fetch, never mid-fetch.
            if (w_last) begin
                r_ir <= insert_byte(r_shadow, r_idx, mem_if.mem_data);
            end
        end
    end

    assign o_ir         = r_ir;
    assign o_fetch_done = r_done;
    assign o_fetch_err  = r_err;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic [31:0] ir;
    logic        done;
    logic        err;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_fetch_if mem_bus ();

    inst_fetch #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .i_reset      (rst),
        .i_fetch_req  (req),
        .i_address    (addr),
        .mem_if       (mem_bus),
        .o_ir         (ir),
        .o_fetch_done (done),
        .o_fetch_err  (err),
        .o_busy       (busy)
    );

    // Advance one cycle; observe 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Complete zero-wait fetch starting in the current cycle (cycle 0).
    task automatic fetch_zero(input string tag, input logic [31:0] a,
                              input logic [31:0] w, input logic [31:0] prev_ir);
        req  = 1'b1;
        addr = a;
        tick;
        req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk32({tag, "_addr"}, mem_bus.mem_addr, a + 32'(k));
            chk1 ({tag, "_rd"},   mem_bus.mem_rd, 1'b1);
            chk1 ({tag, "_busy"}, busy, 1'b1);
            chk32({tag, "_ir_hold"}, ir, prev_ir);
            chk1 ({tag, "_nodone"}, done, 1'b0);
            mem_bus.mem_data  = 8'(w >> (24 - 8 * k));
            mem_bus.mem_valid = 1'b1;
            tick;
        end
        mem_bus.mem_valid = 1'b0;
        chk32({tag, "_ir"},   ir, w);
        chk1 ({tag, "_done"}, done, 1'b1);
        chk1 ({tag, "_err"},  err, 1'b0);
        chk1 ({tag, "_busy_end"}, busy, 1'b0);
        chk1 ({tag, "_rd_end"}, mem_bus.mem_rd, 1'b0);
        $display("fetch %s addr=0x%08h ir=0x%08h done=%b", tag, a, ir, done);
        tick;
        chk1({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 1'b0;
        addr = '0;
        mem_bus.mem_data  = '0;
        mem_bus.mem_valid = 1'b0;
        tick;
        tick;
        // ---- reset state
        chk32("rst_ir",   ir, 32'h0);
        chk32("rst_addr", mem_bus.mem_addr, 32'h0);
        chk1 ("rst_rd",   mem_bus.mem_rd, 1'b0);
        chk1 ("rst_busy", busy, 1'b0);
        chk1 ("rst_done", done, 1'b0);
        chk1 ("rst_err",  err, 1'b0);
        $display("reset ir=0x%08h busy=%b", ir, busy);
        rst = 1'b0;
        // mem_valid with mem_rd=0 must be ignored
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_data  = 8'hFF;
        tick;
        chk1("idle_valid_ignored", busy, 1'b0);
        mem_bus.mem_valid = 1'b0;

        // ---- 1: zero-wait fetch at 0x10
        fetch_zero("zw10", 32'h0000_0010, 32'h1234_5678, 32'h0);

        // ---- 2: two wait cycles before each byte, done in cycle 13
        req  = 1'b1;
        addr = 32'h0000_0020;
        tick;
        req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 3; w++) begin
                chk32("wait_addr", mem_bus.mem_addr, 32'h20 + 32'(k));
                chk1 ("wait_rd",   mem_bus.mem_rd, 1'b1);
                chk32("wait_ir_hold", ir, 32'h1234_5678);
                chk1 ("wait_nodone", done, 1'b0);
                mem_bus.mem_valid = (w == 2);
                mem_bus.mem_data  = (w == 2) ? 8'(32'hA1B2_C3D4 >> (24 - 8 * k)) : 8'h00;
                tick;
            end
        end
        mem_bus.mem_valid = 1'b0;
        chk32("wait_ir",   ir, 32'hA1B2_C3D4);
        chk1 ("wait_done", done, 1'b1);
        chk1 ("wait_busy", busy, 1'b0);
        $display("fetch wait2 addr=0x00000020 ir=0x%08h done=%b", ir, done);
        tick;

        // ---- 3: misaligned 0x6
        req  = 1'b1;
        addr = 32'h0000_0006;
        tick;
        req = 1'b0;
        chk1 ("mis_err",  err, 1'b1);
        chk1 ("mis_done", done, 1'b0);
        chk1 ("mis_rd",   mem_bus.mem_rd, 1'b0);
        chk1 ("mis_busy", busy, 1'b0);
        chk32("mis_ir",   ir, 32'hA1B2_C3D4);
        $display("fetch misaligned addr=0x00000006 err=%b ir=0x%08h", err, ir);
        tick;
        chk1("mis_err_pulse", err, 1'b0);
        chk1("mis_rd_after",  mem_bus.mem_rd, 1'b0);

        // ---- 4: timeout on byte 2 of 0x40
        req  = 1'b1;
        addr = 32'h0000_0040;
        tick;
        req = 1'b0;
        chk32("to_addr0", mem_bus.mem_addr, 32'h40);
        mem_bus.mem_data  = 8'h5A;
        mem_bus.mem_valid = 1'b1;
        tick;
        chk32("to_addr1", mem_bus.mem_addr, 32'h41);
        mem_bus.mem_data = 8'h6B;
        tick;
        mem_bus.mem_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk1 ("to_rd",   mem_bus.mem_rd, 1'b1);
            chk32("to_addr2", mem_bus.mem_addr, 32'h42);
            chk1 ("to_noerr", err, 1'b0);
            tick;
        end
        chk1 ("to_err",  err, 1'b1);
        chk1 ("to_done", done, 1'b0);
        chk1 ("to_rd_end", mem_bus.mem_rd, 1'b0);
        chk1 ("to_busy", busy, 1'b0);
        chk32("to_ir",   ir, 32'hA1B2_C3D4);
        $display("fetch timeout addr=0x00000042 err=%b ir=0x%08h", err, ir);
        tick;
        chk1("to_err_pulse", err, 1'b0);
        fetch_zero("after_to", 32'h0000_0044, 32'h0A0B_0C0D, 32'hA1B2_C3D4);

        // ---- 5: fetch_req held high across two fetches
        req  = 1'b1;
        addr = 32'h0000_0000;
        tick;
        addr = 32'h0000_0004;          // ignored while busy
        for (int k = 0; k < 4; k++) begin
            chk32("b2b1_addr", mem_bus.mem_addr, 32'(k));
            mem_bus.mem_data  = 8'(32'h1122_3344 >> (24 - 8 * k));
            mem_bus.mem_valid = 1'b1;
            tick;
        end
        chk1 ("b2b1_done", done, 1'b1);
        chk32("b2b1_ir",   ir, 32'h1122_3344);
        chk1 ("b2b1_rd",   mem_bus.mem_rd, 1'b0);
        $display("fetch b2b first addr=0x00000000 ir=0x%08h done=%b", ir, done);
        tick;
        for (int k = 0; k < 4; k++) begin
            req = (k == 1);            // pulse during busy must be ignored
            chk1 ("b2b2_rd",   mem_bus.mem_rd, 1'b1);
            chk32("b2b2_addr", mem_bus.mem_addr, 32'h4 + 32'(k));
            mem_bus.mem_data  = 8'(32'h5566_7788 >> (24 - 8 * k));
            mem_bus.mem_valid = 1'b1;
            tick;
        end
        req = 1'b0;
        mem_bus.mem_valid = 1'b0;
        chk1 ("b2b2_done", done, 1'b1);
        chk32("b2b2_ir",   ir, 32'h5566_7788);
        $display("fetch b2b second addr=0x00000004 ir=0x%08h done=%b", ir, done);
        tick;
        chk1("b2b_no_third", busy, 1'b0);

        // ---- 6: reset during byte 1
        req  = 1'b1;
        addr = 32'h0000_0080;
        tick;
        req = 1'b0;
        mem_bus.mem_data  = 8'h99;
        mem_bus.mem_valid = 1'b1;
        tick;
        chk32("rm_addr1", mem_bus.mem_addr, 32'h81);
        rst = 1'b1;
        mem_bus.mem_data = 8'h88;
        tick;
        chk32("rm_ir",   ir, 32'h0);
        chk1 ("rm_rd",   mem_bus.mem_rd, 1'b0);
        chk1 ("rm_busy", busy, 1'b0);
        chk1 ("rm_done", done, 1'b0);
        chk1 ("rm_err",  err, 1'b0);
        chk32("rm_addr", mem_bus.mem_addr, 32'h0);
        $display("reset mid-fetch ir=0x%08h busy=%b", ir, busy);
        rst = 1'b0;
        mem_bus.mem_valid = 1'b0;
        tick;
        chk1("rm_done_after", done, 1'b0);
        chk1("rm_err_after",  err, 1'b0);
        fetch_zero("after_rst", 32'h0000_0084, 32'hCAFE_F00D, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch responder for the multi-cycle CPU: it takes the 32-bit instruction address produced by the program counter and returns the instruction word from the byte-wide instruction memory. It performs four sequential byte reads over a valid-qualified memory port and assembles them big-endian. It then commits the word to the instruction register and pulses completion to the control unit, which uses that pulse to advance its state and enable the next PC write. Misaligned addresses and memory stalls beyond a bounded wait are reported as fetch errors.

## Interface
- TIMEOUT, 16: maximum cycles a single byte read may wait for mem_valid before abort (range 2..255)
- clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- fetch_req  in  1  start a fetch; sampled only when idle
- Address  in  32  instruction byte address from the PC, latched on accept
- mem_rd  out  1  byte read request to instruction memory
- mem_addr  out  32  byte address of the current read
- mem_data  in  8  read data, valid when mem_valid=1
- mem_valid  in  1  memory read-data strobe
- IR  out  32  instruction register
- fetch_done  out  1  one-cycle pulse: IR updated this cycle
- fetch_err  out  1  one-cycle pulse: fetch aborted (misaligned or timeout)
- busy  out  1  fetch in progress

## Operation
- Reset values, held while Reset=1: state IDLE, mem_rd=0, mem_addr=0, IR=0, fetch_done=0, fetch_err=0, busy=0, internal shadow and counters 0.
- IDLE with fetch_req=1:
  - If Address[1:0]≠0: stay IDLE, no memory access, fetch_err=1 next cycle, IR unchanged.
  - Otherwise: latch base=Address, byte index k=0, go to READ.
- READ:
  - mem_rd=1, mem_addr=base+k, stable until a byte is captured.
  - A byte is captured on any cycle with mem_rd=1 and mem_valid=1. Byte k goes to shadow[31-8k -: 8], so byte 0 lands in [31:24].
  - After capture with k<3: k increments and mem_addr updates the next cycle.
  - After capture with k=3: commit IR=shadow, pulse fetch_done, return to IDLE.
- mem_valid while mem_rd=0 is ignored.
- Wait counter:
  - Counts READ cycles without capture; cleared on each capture.
  - When it reaches TIMEOUT without mem_valid: abort to IDLE, pulse fetch_err, IR unchanged.
- IR never changes mid-fetch. It changes only on fetch_done or Reset.
- fetch_req while busy is ignored; there is no queuing.
- base+k wraps modulo 2^32. Alignment guarantees k never carries out of bits [1:0].

## Timing
- Accept at cycle 0 (IDLE, fetch_req=1). busy=1 and mem_rd=1 from cycle 1.
- Zero-wait memory (mem_valid=1 every cycle): bytes are captured in cycles 1–4. IR update and fetch_done both occur in cycle 5, with busy=0 and mem_rd=0.
  - Latency is 5 cycles, plus the wait cycles inserted for each byte.
- Back-to-back: the done/err cycle is an IDLE cycle. A fetch_req in that cycle is accepted, giving a new mem_rd the following cycle.
- Misaligned request at cycle 0: fetch_err in cycle 1. mem_rd stays 0 throughout.
- Timeout: mem_rd high for exactly TIMEOUT cycles on the stalled byte. fetch_err and mem_rd=0 follow in the next cycle.
- Reset mid-fetch takes priority over every event. Outputs return to reset values on the next edge, with no done/err pulse.
- fetch_done and fetch_err are never asserted together.

## Structure
- Shared CPU package holds:
  - state enum {IDLE, READ}
  - width constants INST_W=32 and BYTE_W=8
  - byte-index type (2 bits)
- One sub-module, fetch_wait_timer: a counter with clear, enable and an expired flag, parameterised by TIMEOUT. The FSM and byte assembly stay in inst_fetch.

## Test plan
- Reset, then fetch Address=0x0000_0010 with zero-wait memory returning 0x12,0x34,0x56,0x78 -> mem_addr 0x10..0x13, IR=0x1234_5678 and fetch_done in cycle 5, busy high cycles 1–4.
- Same fetch with 2 wait cycles before each byte -> IR unchanged until cycle 13, then IR=0x1234_5678 and fetch_done=1; mem_addr stable during waits.
- Address=0x0000_0006 -> fetch_err in cycle 1, mem_rd never asserted, IR keeps the prior value.
- Byte 2 never validated with TIMEOUT=16 -> mem_rd high 16 cycles on base+2, then fetch_err; IR unchanged; a next fetch succeeds.
- fetch_req held high across two fetches (0x0, 0x4) -> second mem_rd in the cycle after the first fetch_done; extra fetch_req pulses during busy ignored.
- Reset asserted during byte 1 -> next cycle IR=0, mem_rd=0, busy=0, no done/err pulse; a fresh fetch after release works.
